// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder with programmable read/write wait states
module mem_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int READ_LAT      = 2,
  parameter int WRITE_LAT     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel,
  input  logic                     w_en,
  input  logic [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  output logic                     ready,
  output logic                     abort_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter is loaded with LAT-1, so a 4-bit field covers the 1..15 latency range.
  localparam logic [3:0] RD_CNT_INIT = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_CNT_INIT = 4'(WRITE_LAT - 1);

  // Deliberately not reset so the array can be preloaded from outside.
  logic [DATABUS_WIDTH-1:0] memory [DEPTH];

  logic [1:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic                     wen_q, wen_d;
  logic [DATABUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATABUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                     ready_q, ready_d;
  logic                     abort_q, abort_d;
  logic                     mem_we;
  logic                     bus_oe;

  // Next-state logic: capture in IDLE, count wait states in BUSY, hold response in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    abort_d = abort_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel) begin
          addr_d  = address_bus;
          wen_d   = w_en;
          if (w_en) begin
            wdata_d = data_bus;
          end
          cnt_d   = w_en ? WR_CNT_INIT : RD_CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!sel) begin
          // Initiator gave up: drop the transaction, any pending write is lost.
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (wen_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = memory[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (sel) begin
          // ready is registered one edge after entering RESP, giving LAT+1 edges total.
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
          state_d = S_IDLE;
          if (!ready_q) begin
            abort_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control and datapath registers, cleared asynchronously so reset aborts instantly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      abort_q <= abort_d;
    end
  end

  // Array write on the BUSY->RESP edge; state is forced to IDLE during reset so no partial write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      memory[addr_q] <= wdata_q;
    end
  end

  // Only drive the bus while presenting a read response.
  assign bus_oe    = ready_q && !wen_q && (state_q == S_RESP);
  assign data_bus  = bus_oe ? rdata_q : {DATABUS_WIDTH{1'bz}};
  assign ready     = ready_q;
  assign abort_err = abort_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against an array model
module tb_mem_responder;

  localparam int RL = 2;
  localparam int WL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        w_en;
  logic [7:0]  address_bus;
  logic        tb_oe;
  logic [31:0] tb_data;
  wire  [31:0] data_bus;
  logic        ready;
  logic        abort_err;

  logic [31:0] ref_mem [256];
  logic        ref_abort;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign data_bus = tb_oe ? tb_data : 32'bz;

  mem_responder #(
    .ADDR_WIDTH(8), .DATABUS_WIDTH(32), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .w_en(w_en), .address_bus(address_bus),
    .data_bus(data_bus), .ready(ready), .abort_err(abort_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete handshake; abort_after >= 0 drops sel that many edges after capture.
  task automatic txn(input logic we, input logic [7:0] a, input logic [31:0] wd,
                     input int abort_after, output logic [31:0] rd);
    int lat;
    int lat_exp;
    logic saw_ready;
    rd = '0;
    lat_exp = (we ? WL : RL) + 1;
    sel = 1'b1; w_en = we; address_bus = a; tb_data = wd; tb_oe = we;
    @(posedge clk); #1;
    // Inputs after capture must be ignored.
    tb_oe = 1'b0; w_en = 1'($urandom); address_bus = 8'($urandom);
    if (abort_after >= 0) begin
      repeat (abort_after) begin @(posedge clk); #1; end
      sel = 1'b0;
      saw_ready = 1'b0;
      repeat (lat_exp + 2) begin
        @(posedge clk); #1;
        if (ready) saw_ready = 1'b1;
      end
      ref_abort = 1'b1;
      check("abort_no_ready", 32'(saw_ready), 32'd0);
      check("abort_err_set", 32'(abort_err), 32'(ref_abort));
      return;
    end
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check(we ? "wr_latency" : "rd_latency", 32'(lat), 32'(lat_exp));
    if (we) begin
      check("wr_bus_released", 32'(dut.bus_oe), 32'd0);
      ref_mem[a] = wd;
    end else begin
      rd = data_bus;
      check("rd_data", data_bus, ref_mem[a]);
    end
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    check("ready_held", 32'(ready), 32'd1);
    sel = 1'b0;
    @(posedge clk); #1;
    check("ready_drop", 32'(ready), 32'd0);
    check("bus_release", 32'(dut.bus_oe), 32'd0);
    check("abort_err", 32'(abort_err), 32'(ref_abort));
    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] mx;
    logic [31:0] pool_exp [4];
    int k;
    int lat;
    rst = 1'b0; sel = 1'b0; w_en = 1'b0; address_bus = '0; tb_oe = 1'b0; tb_data = '0;
    ref_abort = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = (i < 16) ? 32'(i + 1) : $urandom;
      dut.memory[i] = ref_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_abort", 32'(abort_err), 32'd0);
    check("reset_bus", 32'(dut.bus_oe), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(ready), 32'd0);

    // Directed: read latency, write-then-read, abort of a write.
    txn(1'b0, 8'd5, '0, -1, rd);
    check("read5", rd, 32'd6);
    txn(1'b1, 8'd20, 32'hDEADBEEF, -1, rd);
    txn(1'b0, 8'd20, '0, -1, rd);
    check("read20", rd, 32'hDEADBEEF);
    txn(1'b1, 8'd3, 32'h55, 0, rd);
    txn(1'b0, 8'd3, '0, -1, rd);
    check("read3_after_abort", rd, 32'd4);
    txn(1'b0, 8'd255, '0, -1, rd);

    // Reset while a read response is on the bus must clear outputs without a clock edge.
    sel = 1'b1; w_en = 1'b0; address_bus = 8'd7;
    lat = 0;
    while (!ready && lat < 40) begin @(posedge clk); #1; lat++; end
    check("midrst_ready_before", 32'(ready), 32'd1);
    check("midrst_data", data_bus, ref_mem[7]);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready_async", 32'(ready), 32'd0);
    check("midrst_bus_async", 32'(dut.bus_oe), 32'd0);
    check("midrst_abort_clr", 32'(abort_err), 32'd0);
    ref_abort = 1'b0;
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 8'd7, '0, -1, rd);

    // Initiator-side 2x2 max-pool over the 4x4 block at address 0, results at 20..23.
    pool_exp[0] = 32'd6; pool_exp[1] = 32'd8; pool_exp[2] = 32'd14; pool_exp[3] = 32'd16;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        mx = '0;
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 2; j++) begin
            txn(1'b0, 8'((2 * r + i) * 4 + 2 * c + j), '0, -1, rd);
            if (rd > mx) mx = rd;
          end
        end
        txn(1'b1, 8'(20 + 2 * r + c), mx, -1, rd);
      end
    end
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, 8'(20 + i), '0, -1, rd);
      check("pool_out", rd, pool_exp[i]);
    end

    // Randomized mix of reads, writes and aborted requests.
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        txn(1'($urandom), 8'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, WL - 1), rd);
      end else if (k < 5) begin
        txn(1'b1, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)),
            $urandom, -1, rd);
      end else begin
        txn(1'b0, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)),
            '0, -1, rd);
      end
    end

    // Sweep the hot region so any write leaking through an abort is caught.
    for (int i = 0; i < 32; i++) begin
      txn(1'b0, 8'(i), '0, -1, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
